serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, LSB-first two's-complement subtractor computing diff = a - b - bin, one bit per clock through a single full-subtractor cell.
- Inverse-direction companion to the ALU's adder datapath; used where area matters more than latency.
- Valid/ready handshake on both operand input and result output.

Parameters:
- WIDTH, 16, operand and result width in bits (legal range 2..64).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start_valid  input  1  operands a, b, bin are valid.
- start_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- res_valid  output  1  diff and bout are valid.
- res_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow-out; 1 when unsigned a < b + bin.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- FSM states: IDLE, BUSY, DONE.
- Reset, applied asynchronously and held while rst=1:
  - state=IDLE, count=0, operand shift registers=0, borrow=0.
  - diff=0, bout=0, res_valid=0.
  - start_ready=0 while rst=1.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready: capture a into a_sh, b into b_sh, bin into borrow; clear diff; count=0; next state BUSY.
- BUSY, every cycle:
  - Full-subtractor cell: d = a_sh[0]^b_sh[0]^borrow; bo = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&borrow).
  - diff <= {d, diff[WIDTH-1:1]}; a_sh and b_sh shift right by 1; borrow <= bo; count++.
  - When count==WIDTH-1, the final bo loads into bout and next state is DONE.
- Latency: res_valid rises exactly WIDTH cycles after the accepting edge.
- DONE:
  - res_valid=1.
  - diff and bout held stable until handshake.
  - On res_ready=1, next state IDLE and res_valid drops the following cycle.
  - diff and bout keep their last values until the next acceptance.
- start_ready=0 in BUSY and DONE. start_valid in those states is ignored with no queueing.
- Simultaneous res_ready and start_valid in DONE: result completes; new operands are not accepted until the following IDLE cycle.
- Throughput: one result per WIDTH+2 cycles with zero backpressure.
- Reset mid-BUSY or mid-DONE: operation aborted, no result produced.
- Operand inputs only need to be stable on the accepting edge.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), the signed overflow flag.
  - ovf = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb), using the sign bits captured at acceptance.
  - Valid with res_valid, 0 on reset, held with diff.
- Undefined: port, sign registers and logic absent; all other behaviour identical.

Decomposition:
- Shared package alu_pkg holds:
  - state typedef sub_state_t {IDLE, BUSY, DONE}.
  - Default width constant ALU_WIDTH=16.
- One sub-module, full_subtractor (x, y, bi -> d, bo), purely combinational, instanced once.

Test Plan (WIDTH=8):
- a=0x35, b=0x12, bin=0, res_ready=1 -> after 8 cycles diff=0x23, bout=0; res_valid high exactly 1 cycle.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1.
- a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1.
- a=0x35, b=0x12 with res_ready=0 for 5 cycles; pulse start_valid with other operands during DONE -> res_valid and diff=0x23 stable; start_ready=0; second op ignored; after res_ready, IDLE.
- Assert rst on 3rd BUSY cycle -> diff=0, bout=0, res_valid=0 immediately; then a=0x05, b=0x03 -> diff=0x02, bout=0.
- SERIAL_SUB_OVF_EN defined:
  - a=0x80, b=0x01 -> diff=0x7F, ovf=1.
  - a=0x7F, b=0xFF -> diff=0x80, ovf=1.
  - a=0x05, b=0x03 -> ovf=0.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared ALU package: the subtractor state type and the default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } sub_state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full-subtractor cell: d = x - y - bi, bo = borrow out of this bit.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (diff = a - b - bin) with valid/ready on both sides.
// Optional signed overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  sub_state_t       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_count;
  logic             r_borrow;
  logic             r_bout;
  logic             w_d;
  logic             w_bo;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
`endif

  full_subtractor u_fs (
    .x  (r_a_sh[0]),
    .y  (r_b_sh[0]),
    .bi (r_borrow),
    .d  (w_d),
    .bo (w_bo)
  );

  // The last computed bit lands in diff's MSB, so w_d is the result sign on the final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_diff   <= '0;
      r_count  <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_borrow <= bin;
            r_diff   <= '0;
            r_count  <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
`endif
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          r_diff   <= {w_d, r_diff[WIDTH-1:1]};
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_borrow <= w_bo;
          r_count  <= r_count + CW'(1);
          if (r_count == CW'(WIDTH - 1)) begin
            r_bout  <= w_bo;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
            r_state <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign start_ready = (r_state == IDLE) && !rst;
  assign res_valid   = (r_state == DONE);
  assign diff        = r_diff;
  assign bout        = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf         = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8: vector table, corner sequences, random ops.
// Define SERIAL_SUB_OVF_EN to also exercise the overflow output.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int nApplied;
  int nMiscompares;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vbin;
    logic [W-1:0] expDiff;
    logic         expBout;
    logic         expOvf;
  } vector_t;

  vector_t vectors[10];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .bin         (bin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .diff        (diff),
    .bout        (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nApplied++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Presents one operand set in IDLE, then returns once res_valid is seen (or a bound expires).
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tbin, output int lat);
    @(negedge clk);
    a = ta;
    b = tb;
    bin = tbin;
    start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic runVector(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                           input logic [W-1:0] eDiff, input logic eBout, input logic eOvf);
    int lat;
    applyStimulus(ta, tb, tbin, lat);
    checkOutput("latency", 64'(lat), 64'(W));
    checkOutput("diff", 64'(diff), 64'(eDiff));
    checkOutput("bout", 64'(bout), 64'(eBout));
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("ovf", 64'(ovf), 64'(eOvf));
`else
    if (eOvf === 1'bx) $display("[TB] unexpected X in expected ovf");
`endif
    @(posedge clk);
    #1 checkOutput("res_valid_pulse", 64'(res_valid), 64'd0);
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                                output logic [W-1:0] mDiff, output logic mBout, output logic mOvf);
    int full;
    full  = int'(ma) - int'(mb) - int'(mbin);
    mDiff = W'(full);
    mBout = (full < 0);
    mOvf  = (ma[W-1] != mb[W-1]) && (mDiff[W-1] != ma[W-1]);
  endfunction

  initial begin
    int lat;
    logic [W-1:0] ra, rb, mDiff;
    logic rbin, mBout, mOvf;

    nApplied     = 0;
    nMiscompares = 0;
    vectors[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
    vectors[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vectors[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
    vectors[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vectors[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vectors[5] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vectors[6] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
    vectors[7] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    vectors[8] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
    vectors[9] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b1};

    rst         = 1'b1;
    start_valid = 1'b0;
    res_ready   = 1'b1;
    a           = '0;
    b           = '0;
    bin         = 1'b0;

    #1;
    checkOutput("reset_diff", 64'(diff), 64'd0);
    checkOutput("reset_bout", 64'(bout), 64'd0);
    checkOutput("reset_res_valid", 64'(res_valid), 64'd0);
    checkOutput("reset_start_ready", 64'(start_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 checkOutput("idle_start_ready", 64'(start_ready), 64'd1);

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) begin
      runVector(vectors[i].va, vectors[i].vb, vectors[i].vbin,
                vectors[i].expDiff, vectors[i].expBout, vectors[i].expOvf);
    end

    $display("[TB] backpressure with ignored start during DONE");
    res_ready = 1'b0;
    applyStimulus(8'h35, 8'h12, 1'b0, lat);
    checkOutput("bp_latency", 64'(lat), 64'(W));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a = 8'hFF;
        b = 8'h00;
        start_valid = 1'b1;
      end else begin
        start_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      checkOutput("bp_res_valid", 64'(res_valid), 64'd1);
      checkOutput("bp_diff", 64'(diff), 64'h23);
      checkOutput("bp_start_ready", 64'(start_ready), 64'd0);
    end
    @(negedge clk);
    res_ready   = 1'b1;
    start_valid = 1'b1;
    a = 8'h01;
    b = 8'h01;
    @(posedge clk);
    #1 start_valid = 1'b0;
    checkOutput("simul_res_valid", 64'(res_valid), 64'd0);
    checkOutput("simul_start_ready", 64'(start_ready), 64'd1);
    checkOutput("held_diff", 64'(diff), 64'h23);
    checkOutput("held_bout", 64'(bout), 64'd0);
    repeat (3) @(posedge clk);
    #1 checkOutput("no_ghost_result", 64'(res_valid), 64'd0);

    $display("[TB] reset in the third BUSY cycle");
    runVector(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    @(negedge clk);
    a = 8'h35;
    b = 8'h12;
    bin = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_diff", 64'(diff), 64'd0);
    checkOutput("abort_bout", 64'(bout), 64'd0);
    checkOutput("abort_res_valid", 64'(res_valid), 64'd0);
    checkOutput("abort_start_ready", 64'(start_ready), 64'd0);
    @(negedge clk) rst = 1'b0;
    repeat (W + 2) @(posedge clk);
    #1 checkOutput("abort_no_result", 64'(res_valid), 64'd0);
    runVector(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

    $display("[TB] random operands against model");
    for (int i = 0; i < 30; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom_range(0, 1));
      model(ra, rb, rbin, mDiff, mBout, mOvf);
      runVector(ra, rb, rbin, mDiff, mBout, mOvf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
    $finish;
  end

endmodule
